// File: rtl/spi_slave_if.sv
// Pin-side SPI signals plus the byte-wide TX/RX handshake of the SPI responder.
// The slave modport is the responder's view; master is the view of whoever drives it.
interface spi_slave_if;
  logic       spi_cs;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  modport slave (
    input  spi_cs, spi_clk, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output spi_cs, spi_clk, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, oversampling cs/sck/mosi in the clk domain.
// Byte-wide TX holding register (valid/ready) and RX byte output with a valid pulse.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_mosi_sync;
  logic                   r_cs_d, r_sck_d;
  logic                   r_sck_rise, r_sck_fall, r_mosi_smp;
  state_t                 r_state, w_state_next;
  logic [7:0]             r_hold;
  logic                   r_hold_full;
  logic [6:0]             r_tx_shift;
  logic [6:0]             r_rx_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_reload;
  logic                   r_miso, r_miso_oe;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid, r_underrun;

  logic       w_cs_s, w_sck_s, w_mosi_s, w_cs_fall;
  logic       w_load, w_shift, w_sample, w_abort, w_capture;
  logic [7:0] w_load_byte, w_rx_byte;

  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_capture   = bus.tx_valid & ~r_hold_full;
  assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;
  assign w_rx_byte   = {r_rx_shift, r_mosi_smp};

  // SCK edges are registered once more so that MISO updates and rx_valid land
  // SYNC_STAGES+2 cycles after the pin edge, matching the CS-fall -> LOAD path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sck_d     <= 1'b0;
      r_sck_rise  <= 1'b0;
      r_sck_fall  <= 1'b0;
      r_mosi_smp  <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_cs_d      <= w_cs_s;
      r_sck_d     <= w_sck_s;
      r_sck_rise  <= w_sck_s & ~r_sck_d;
      r_sck_fall  <= ~w_sck_s & r_sck_d;
      r_mosi_smp  <= w_mosi_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Deselect is checked on the level so it always wins over a pending SCK edge.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_sample     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_cs_s) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_s) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_sample = r_sck_rise;
          w_load   = r_sck_fall & r_reload;
          w_shift  = r_sck_fall & ~r_reload;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_tx_shift  <= 7'h00;
      r_rx_shift  <= 7'h00;
      r_bit_cnt   <= 3'd0;
      r_reload    <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (w_capture) r_hold <= bus.tx_data;
      // A load empties the holding register; a byte captured in the same
      // cycle (only possible when it was already empty) refills it.
      if (w_load)         r_hold_full <= w_capture;
      else if (w_capture) r_hold_full <= 1'b1;

      if (w_load) begin
        r_tx_shift <= w_load_byte[6:0];
        r_miso     <= w_load_byte[7];
        r_miso_oe  <= 1'b1;
        r_underrun <= ~r_hold_full;
        r_reload   <= 1'b0;
        r_bit_cnt  <= 3'd0;
      end
      if (w_shift) begin
        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
      if (w_sample) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= w_rx_byte;
          r_rx_valid <= 1'b1;
          r_reload   <= 1'b1;
        end
      end
      if (w_abort) begin
        r_miso     <= 1'b0;
        r_miso_oe  <= 1'b0;
        r_rx_shift <= 7'h00;
        r_bit_cnt  <= 3'd0;
        r_reload   <= 1'b0;
      end
    end
  end

  assign bus.spi_miso    = r_miso;
  assign bus.spi_miso_oe = r_miso_oe;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_underrun;
  assign bus.busy        = ~w_cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives SPI mode-0 pins at half-period HALF clk
// cycles, feeds TX bytes and logs rx_valid / tx_underrun pulses every cycle.
module tb_spi_slave;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if ifc();

  spi_slave #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int         checks = 0;
  int         passed = 0;
  int         rx_cnt = 0;
  int         un_cnt = 0;
  logic [7:0] rx_log [0:7];
  logic [7:0] feed   [0:3];
  int         feed_n = 0;
  int         feed_idx = 0;
  bit         feed_en = 1'b0;
  int         inj_delay = -1;
  logic [7:0] inj_data = 8'h00;

  // One clock step: log pulses, then drive tx_valid from feeder / injector.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.rx_valid) begin
      if (rx_cnt < 8) rx_log[rx_cnt] = ifc.rx_data;
      rx_cnt++;
    end
    if (ifc.tx_underrun) un_cnt++;
    if (ifc.tx_valid) ifc.tx_valid = 1'b0;
    else if (inj_delay == 0) begin
      ifc.tx_data  = inj_data;
      ifc.tx_valid = 1'b1;
      inj_delay    = -1;
    end else if (feed_en && ifc.tx_ready && feed_idx < feed_n) begin
      ifc.tx_data  = feed[feed_idx];
      ifc.tx_valid = 1'b1;
      feed_idx++;
    end
    if (inj_delay > 0) inj_delay--;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit inject,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      ifc.spi_mosi = mo[7-k];
      repeat (HALF) tick();
      mi[7-k] = ifc.spi_miso;
      ifc.spi_clk = 1'b1;
      repeat (HALF) tick();
      ifc.spi_clk = 1'b0;
    end
    if (inject) inj_delay = SS;
  endtask

  task automatic cs_end();
    repeat (HALF) tick();
    ifc.spi_cs = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic clear_logs();
    rx_cnt = 0;
    un_cnt = 0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    repeat (3) tick();
    obs = {ifc.spi_miso, ifc.spi_miso_oe, ifc.tx_ready, ifc.rx_data, ifc.rx_valid, ifc.tx_underrun, ifc.busy};
    checks++; if (obs !== 14'b0_0_1_00000000_0_0_0) $display("FAIL reset_hold: got %b want %b", obs, 14'b0_0_1_00000000_0_0_0); else passed++;
    rst_n = 1'b1;
    repeat (4) tick();
    obs = {ifc.spi_miso, ifc.spi_miso_oe, ifc.tx_ready, ifc.rx_data, ifc.rx_valid, ifc.tx_underrun, ifc.busy};
    checks++; if (obs !== 14'b0_0_1_00000000_0_0_0) $display("FAIL reset_release: got %b want %b", obs, 14'b0_0_1_00000000_0_0_0); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] mi;
    clear_logs();
    ifc.tx_data  = 8'hA5;
    ifc.tx_valid = 1'b1;
    tick();
    checks++; if (ifc.tx_ready !== 1'b0) $display("FAIL single_ready_full: got %b want 0", ifc.tx_ready); else passed++;
    ifc.spi_cs = 1'b0;
    repeat (SS + 3) tick();
    checks++; if (ifc.tx_ready !== 1'b1) $display("FAIL single_ready_after_load: got %b want 1", ifc.tx_ready); else passed++;
    checks++; if ({ifc.spi_miso_oe, ifc.busy} !== 2'b11) $display("FAIL single_oe_busy: got %b want 11", {ifc.spi_miso_oe, ifc.busy}); else passed++;
    spi_bits(8'h3C, 8, 1'b0, mi);
    cs_end();
    checks++; if (mi !== 8'hA5) $display("FAIL single_miso: got %h want a5", mi); else passed++;
    checks++; if (ifc.rx_data !== 8'h3C) $display("FAIL single_rx_data: got %h want 3c", ifc.rx_data); else passed++;
    checks++; if (rx_cnt !== 1) $display("FAIL single_rx_pulses: got %0d want 1", rx_cnt); else passed++;
    checks++; if (rx_log[0] !== 8'h3C) $display("FAIL single_rx_at_valid: got %h want 3c", rx_log[0]); else passed++;
    $display("test_single: miso=%h rx=%h pulses=%0d", mi, ifc.rx_data, rx_cnt);
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    clear_logs();
    ifc.spi_cs = 1'b0;
    spi_bits(8'h00, 8, 1'b0, mi);
    checks++; if (un_cnt !== 1) $display("FAIL underrun_pulses: got %0d want 1", un_cnt); else passed++;
    cs_end();
    checks++; if (mi !== 8'hFF) $display("FAIL underrun_miso: got %h want ff", mi); else passed++;
    checks++; if ({rx_cnt == 1, ifc.rx_data} !== {1'b1, 8'h00}) $display("FAIL underrun_rx: got cnt=%0d data=%h want cnt=1 data=00", rx_cnt, ifc.rx_data); else passed++;
    $display("test_underrun: miso=%h underruns=%0d rx=%h", mi, un_cnt, ifc.rx_data);
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi [0:2];
    logic [7:0] exp_mi [0:2];
    logic [7:0] mo [0:2];
    exp_mi[0] = 8'h11; exp_mi[1] = 8'h22; exp_mi[2] = 8'h33;
    mo[0] = 8'hDE; mo[1] = 8'hAD; mo[2] = 8'hBE;
    clear_logs();
    feed[0] = 8'h11; feed[1] = 8'h22; feed[2] = 8'h33;
    feed_n = 3; feed_idx = 0; feed_en = 1'b1;
    repeat (3) tick();
    ifc.spi_cs = 1'b0;
    for (int b = 0; b < 3; b++) spi_bits(mo[b], 8, 1'b0, mi[b]);
    cs_end();
    feed_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      checks++; if (mi[b] !== exp_mi[b]) $display("FAIL burst_miso%0d: got %h want %h", b, mi[b], exp_mi[b]); else passed++;
      checks++; if (rx_log[b] !== mo[b]) $display("FAIL burst_rx%0d: got %h want %h", b, rx_log[b], mo[b]); else passed++;
    end
    checks++; if (rx_cnt !== 3) $display("FAIL burst_rx_pulses: got %0d want 3", rx_cnt); else passed++;
    $display("test_back_to_back: miso=%h %h %h pulses=%0d", mi[0], mi[1], mi[2], rx_cnt);
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    clear_logs();
    ifc.spi_cs = 1'b0;
    spi_bits(8'hF0, 5, 1'b0, mi);
    cs_end();
    checks++; if (rx_cnt !== 0) $display("FAIL abort_no_rx: got %0d want 0", rx_cnt); else passed++;
    checks++; if ({ifc.spi_miso_oe, ifc.busy} !== 2'b00) $display("FAIL abort_idle: got %b want 00", {ifc.spi_miso_oe, ifc.busy}); else passed++;
    ifc.spi_cs = 1'b0;
    spi_bits(8'h81, 8, 1'b0, mi);
    cs_end();
    checks++; if (ifc.rx_data !== 8'h81) $display("FAIL abort_next_rx: got %h want 81", ifc.rx_data); else passed++;
    checks++; if (rx_cnt !== 1) $display("FAIL abort_next_pulses: got %0d want 1", rx_cnt); else passed++;
    checks++; if (mi !== 8'hFF) $display("FAIL abort_next_miso: got %h want ff", mi); else passed++;
    $display("test_abort: rx=%h pulses=%0d miso=%h", ifc.rx_data, rx_cnt, mi);
  endtask

  task automatic test_reset_mid();
    logic [7:0]  mi;
    logic [13:0] obs;
    clear_logs();
    ifc.spi_cs = 1'b0;
    spi_bits(8'hC3, 3, 1'b0, mi);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    obs = {ifc.spi_miso, ifc.spi_miso_oe, ifc.tx_ready, ifc.rx_data, ifc.rx_valid, ifc.tx_underrun, ifc.busy};
    checks++; if (obs !== 14'b0_0_1_00000000_0_0_0) $display("FAIL rstmid_async: got %b want %b", obs, 14'b0_0_1_00000000_0_0_0); else passed++;
    ifc.spi_cs   = 1'b1;
    ifc.spi_clk  = 1'b0;
    ifc.spi_mosi = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if ({ifc.spi_miso_oe, ifc.busy, rx_cnt == 0} !== 3'b001) $display("FAIL rstmid_stays_idle: got %b want 001", {ifc.spi_miso_oe, ifc.busy, rx_cnt == 0}); else passed++;
    ifc.spi_cs = 1'b0;
    spi_bits(8'h5A, 8, 1'b0, mi);
    cs_end();
    checks++; if (ifc.rx_data !== 8'h5A) $display("FAIL rstmid_rx: got %h want 5a", ifc.rx_data); else passed++;
    checks++; if (mi !== 8'hFF) $display("FAIL rstmid_miso: got %h want ff", mi); else passed++;
    $display("test_reset_mid: rx=%h miso=%h", ifc.rx_data, mi);
  endtask

  task automatic test_load_collision();
    logic [7:0] mi0, mi1, mi2;
    int         un_after1;
    clear_logs();
    ifc.tx_data  = 8'h44;
    ifc.tx_valid = 1'b1;
    tick();
    inj_data   = 8'h77;
    ifc.spi_cs = 1'b0;
    spi_bits(8'h12, 8, 1'b1, mi0);
    un_after1 = un_cnt;
    spi_bits(8'h34, 8, 1'b0, mi1);
    checks++; if (un_cnt - un_after1 !== 1) $display("FAIL collide_underrun: got %0d want 1", un_cnt - un_after1); else passed++;
    spi_bits(8'h56, 8, 1'b0, mi2);
    cs_end();
    checks++; if (mi0 !== 8'h44) $display("FAIL collide_miso0: got %h want 44", mi0); else passed++;
    checks++; if (mi1 !== 8'hFF) $display("FAIL collide_miso1: got %h want ff", mi1); else passed++;
    checks++; if (mi2 !== 8'h77) $display("FAIL collide_miso2: got %h want 77", mi2); else passed++;
    checks++; if ({rx_log[0], rx_log[1], rx_log[2]} !== 24'h123456) $display("FAIL collide_rx: got %h want 123456", {rx_log[0], rx_log[1], rx_log[2]}); else passed++;
    $display("test_load_collision: miso=%h %h %h", mi0, mi1, mi2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.spi_cs   = 1'b1;
    ifc.spi_clk  = 1'b0;
    ifc.spi_mosi = 1'b0;
    ifc.tx_data  = 8'h00;
    ifc.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_load_collision();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
